key_event: RTL and testbench
============================

# key_event

Event generator that sits directly downstream of the debouncer and consumes its filtered level (`data_out`). It classifies clean press/release activity into press, short-release, long-press and auto-repeat events, and timestamps each with hold duration. Each event is presented through a single-entry valid/ack register to the register/interrupt logic. A sticky overflow flag records events dropped while the register was full.

## Interface
- `CLK_PER_TICK`, 1_000_000, clock cycles per hold-time tick (10 ms at 100 MHz)
- `HOLD_W`, 16, width of hold-time counter and `evt_hold`

- `clk`  in  1  system clock, 100 MHz
- `res`  in  1  reset, synchronous, active-high
- `ena`  in  1  block enable; 0 forces idle
- `long_time`  in  8  long-press threshold in ticks; 0 disables long/repeat
- `rep_time`  in  8  auto-repeat period in ticks; 0 disables repeat
- `data_in`  in  1  debounced level, 1 = pressed
- `evt_valid`  out  1  event register holds an unconsumed event
- `evt_code`  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- `evt_hold`  out  HOLD_W  hold time in ticks at event generation
- `evt_ack`  in  1  consumer accepts the event
- `ovf`  out  1  sticky: an event was dropped
- `ovf_clr`  in  1  clears `ovf`
- `pressed`  out  1  FSM is not IDLE

## Operation
- `d_q` registers `data_in` every cycle. Edge = (`data_in` != `d_q`) while `ena`=1.
- FSM states: IDLE, HELD, LONG.
  - IDLE: on a rising edge, emit PRESS with hold=0, clear hold and prescaler, go to HELD.
  - HELD: each tick, hold+1. When hold+1 == `long_time` and `long_time` != 0, emit LONG with the new hold, clear repeat count, go to LONG. On a falling edge, emit RELEASE with the current hold, go to IDLE.
  - LONG: each tick, hold+1 (saturating at all-ones) and rep+1. When rep+1 == `rep_time` and `rep_time` != 0, emit REPEAT and clear rep. On a falling edge, emit RELEASE, go to IDLE.
- Tick prescaler counts 0..`CLK_PER_TICK`-1 and fires at terminal count. It restarts at 0 on PRESS and runs only outside IDLE.
- Simultaneous falling edge and tick: RELEASE wins. That tick is ignored, so hold does not increment and no LONG/REPEAT is emitted.
- Event register:
  - Loads when `evt_valid`=0, or `evt_valid`=1 with `evt_ack`=1 in the same cycle (back-to-back is lossless).
  - Otherwise the new event is dropped and `ovf` is set.
  - `evt_ack` with `evt_valid`=0 is ignored.
- `ovf` set and `ovf_clr` in the same cycle: set wins.
- `ena`=0:
  - FSM goes to IDLE; hold, rep and prescaler are cleared; no events are generated.
  - `d_q` keeps tracking `data_in`, so re-enable while held produces no PRESS.
  - The event register and `ovf` keep their state and the ack/clear handshakes still operate.
- Hold and rep counters saturate and never wrap.
- `long_time` and `rep_time` are sampled live. Lowering one below the current count prevents a match until the next press (no wrap).

## Timing
- Reset values: `evt_valid`=0, `evt_code`=00, `evt_hold`=0, `ovf`=0, `pressed`=0, `d_q`=0, state IDLE, all counters 0.
- `data_in`=1 at reset release produces a PRESS, because `d_q` resets to 0.
- Edge sampled at clock n → `evt_valid`/`evt_code`/`evt_hold` and `pressed` updated at n+1.
- First tick occurs exactly `CLK_PER_TICK` cycles after the PRESS clock.
- `evt_ack` at clock n → `evt_valid`=0 at n+1, unless a new event loads at n.
- Reset mid-operation: all state returns to reset values on the next clock. A pending event is lost; no event is emitted for the reset.

## Structure
- `key_event_pkg`: event code constants (`EVT_PRESS`, `EVT_RELEASE`, `EVT_LONG`, `EVT_REPEAT`) and FSM state encoding.
- Sub-module `tick_gen`: parameterised prescaler with `clk`, `res`, `run`, `restart`, `tick`. FSM, counters and event register stay in `key_event`.

## Test plan
All scenarios use `CLK_PER_TICK`=4.
- Press, hold 2 ticks, release, `long_time`=5 → PRESS (hold 0), then RELEASE (hold 2); `pressed` high between them; no LONG.
- `long_time`=3, `rep_time`=2, hold 9 ticks, consumer acks every event immediately → PRESS(0), LONG(3), REPEAT(5), REPEAT(7), REPEAT(9), RELEASE(9); `ovf`=0.
- No ack after PRESS; press then release → RELEASE dropped; `ovf`=1; `evt_code` stays PRESS. Pulse `ovf_clr` → `ovf`=0.
- `ack` coincident with a new event → new event is loaded and `evt_valid` stays 1.
- Falling edge on the same clock as the tick that would reach `long_time` → RELEASE with the pre-tick hold; no LONG.
- `ena` dropped while in LONG, then `data_in` released, then `ena` raised → FSM IDLE, no RELEASE, no spurious PRESS. Assert `res` while `evt_valid`=1 → all outputs 0 on the next clock.

Source files
------------

// File: rtl/key_event_pkg.sv
// key_event_pkg: event codes and FSM state encoding for key_event
package key_event_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_e;
    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;
endpackage

// File: rtl/key_event_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick at terminal count, held at 0 while idle
module tick_gen #(
    parameter int CLK_PER_TICK = 1_000_000
) (
    input  logic clk,
    input  logic res,
    input  logic run,
    input  logic restart,
    output logic tick
);
    localparam int CW = CLK_PER_TICK > 1 ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_PER_TICK - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = run && cnt_q == TC;
    always_comb cnt_d = (restart || !run || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/key_event.sv
// key_event: classifies debounced key activity into timestamped press/release/long/repeat events
module key_event
    import key_event_pkg::*;
#(
    parameter int CLK_PER_TICK = 1_000_000,
    parameter int HOLD_W       = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              ena,
    input  logic [7:0]        long_time,
    input  logic [7:0]        rep_time,
    input  logic              data_in,
    output logic              evt_valid,
    output logic [1:0]        evt_code,
    output logic [HOLD_W-1:0] evt_hold,
    input  logic              evt_ack,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              pressed
);
    state_e            state_q, state_d;
    logic              d_q;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc, ev_hold;
    logic [7:0]        rep_q, rep_d, rep_inc;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic [1:0]        code_q, code_d, ev_code;
    logic [HOLD_W-1:0] evh_q, evh_d;
    logic              rise, fall, tick, restart, fire, load;

    assign rise     = ena && data_in && !d_q;
    assign fall     = ena && !data_in && d_q;
    assign hold_inc = &hold_q ? hold_q : hold_q + 1'b1;
    assign rep_inc  = &rep_q ? rep_q : rep_q + 1'b1;

    tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
        .clk(clk), .res(res), .run(ena && state_q != ST_IDLE), .restart(restart), .tick(tick)
    );

    // A falling edge always takes priority over a coincident tick.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        fire    = 1'b0;
        ev_code = EVT_PRESS;
        ev_hold = '0;
        restart = 1'b0;
        if (!ena) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            rep_d   = '0;
        end else if (state_q == ST_IDLE) begin
            if (rise) begin
                fire    = 1'b1;
                hold_d  = '0;
                rep_d   = '0;
                restart = 1'b1;
                state_d = ST_HELD;
            end
        end else if (fall) begin
            fire    = 1'b1;
            ev_code = EVT_RELEASE;
            ev_hold = hold_q;
            state_d = ST_IDLE;
        end else if (tick) begin
            hold_d = hold_inc;
            if (state_q == ST_HELD) begin
                if (long_time != 8'd0 && hold_inc == HOLD_W'(long_time)) begin
                    fire    = 1'b1;
                    ev_code = EVT_LONG;
                    ev_hold = hold_inc;
                    rep_d   = '0;
                    state_d = ST_LONG;
                end
            end else begin
                rep_d = rep_inc;
                if (rep_time != 8'd0 && rep_inc == rep_time) begin
                    fire    = 1'b1;
                    ev_code = EVT_REPEAT;
                    ev_hold = hold_inc;
                    rep_d   = '0;
                end
            end
        end
    end

    always_comb begin
        load    = fire && (!valid_q || evt_ack);
        valid_d = load ? 1'b1 : (evt_ack ? 1'b0 : valid_q);
        code_d  = load ? ev_code : code_q;
        evh_d   = load ? ev_hold : evh_q;
        ovf_d   = (fire && !load) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            d_q     <= 1'b0;
            hold_q  <= '0;
            rep_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= EVT_PRESS;
            evh_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= data_in;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            evh_q   <= evh_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign evt_hold  = evh_q;
    assign ovf       = ovf_q;
    assign pressed   = state_q != ST_IDLE;
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: scoreboard-driven bench for key_event with CLK_PER_TICK = 4
module tb_key_event;
    import key_event_pkg::*;
    localparam int HW = 16;
    typedef struct packed {logic [1:0] code; logic [HW-1:0] hold;} evt_t;

    logic          clk = 1'b0;
    logic          res, ena, data_in, ovf_clr, man_ack, auto_ack;
    logic          mon_ack = 1'b0;
    logic          evt_ack;
    logic [7:0]    long_time, rep_time;
    logic          evt_valid, ovf, pressed;
    logic [1:0]    evt_code;
    logic [HW-1:0] evt_hold;
    evt_t          exp_q[$];
    int            checks = 0, passes = 0;

    always #5 clk = ~clk;
    assign evt_ack = man_ack | mon_ack;

    key_event #(.CLK_PER_TICK(4), .HOLD_W(HW)) dut (
        .clk(clk), .res(res), .ena(ena), .long_time(long_time), .rep_time(rep_time),
        .data_in(data_in), .evt_valid(evt_valid), .evt_code(evt_code), .evt_hold(evt_hold),
        .evt_ack(evt_ack), .ovf(ovf), .ovf_clr(ovf_clr), .pressed(pressed)
    );

    // Consumer that acks every event it sees and checks it against the scoreboard.
    always @(negedge clk) begin
        evt_t e;
        mon_ack = 1'b0;
        if (auto_ack && evt_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got code=%0d hold=%0d, required no event", evt_code, evt_hold);
            end else begin
                e = exp_q.pop_front();
                if ({evt_code, evt_hold} !== e)
                    $display("FAIL event: got code=%0d hold=%0d, required code=%0d hold=%0d", evt_code, evt_hold, e.code, e.hold);
                else passes++;
            end
            mon_ack = 1'b1;
        end
    end

    task automatic reset_dut;
        @(negedge clk);
        res = 1'b1; ena = 1'b1; data_in = 1'b0; man_ack = 1'b0; ovf_clr = 1'b0;
        auto_ack = 1'b0; long_time = 8'd0; rep_time = 8'd0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset_dut();
        checks++; if (evt_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", evt_valid); else passes++;
        checks++; if (evt_code !== 2'b00) $display("FAIL rst_code: got %b, required 00", evt_code); else passes++;
        checks++; if (evt_hold !== '0) $display("FAIL rst_hold: got %0d, required 0", evt_hold); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b, required 0", ovf); else passes++;
        checks++; if (pressed !== 1'b0) $display("FAIL rst_pressed: got %b, required 0", pressed); else passes++;
    endtask

    task automatic test_press_release;
        reset_dut();
        long_time = 8'd5; auto_ack = 1'b1;
        exp_q.push_back('{EVT_PRESS, 16'd0});
        exp_q.push_back('{EVT_RELEASE, 16'd2});
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (pressed !== 1'b1) $display("FAIL pr_pressed: got %b, required 1", pressed); else passes++;
        repeat (5) @(negedge clk);
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (pressed !== 1'b0) $display("FAIL pr_idle: got %b, required 0", pressed); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL pr_missing: got %0d events left, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_long_repeat;
        reset_dut();
        long_time = 8'd3; rep_time = 8'd2; auto_ack = 1'b1;
        exp_q.push_back('{EVT_PRESS, 16'd0});
        exp_q.push_back('{EVT_LONG, 16'd3});
        exp_q.push_back('{EVT_REPEAT, 16'd5});
        exp_q.push_back('{EVT_REPEAT, 16'd7});
        exp_q.push_back('{EVT_REPEAT, 16'd9});
        exp_q.push_back('{EVT_RELEASE, 16'd9});
        data_in = 1'b1;
        repeat (38) @(negedge clk);
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (exp_q.size() != 0) $display("FAIL lr_missing: got %0d events left, required 0", exp_q.size()); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL lr_ovf: got %b, required 0", ovf); else passes++;
    endtask

    task automatic test_overflow;
        reset_dut();
        data_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (evt_valid !== 1'b1) $display("FAIL of_valid: got %b, required 1", evt_valid); else passes++;
        data_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ovf !== 1'b1) $display("FAIL of_set: got %b, required 1", ovf); else passes++;
        checks++; if (evt_code !== EVT_PRESS) $display("FAIL of_code: got %b, required %b", evt_code, EVT_PRESS); else passes++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) $display("FAIL of_clr: got %b, required 0", ovf); else passes++;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (evt_valid !== 1'b0) $display("FAIL of_ack: got %b, required 0", evt_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        reset_dut();
        data_in = 1'b1;
        repeat (2) @(negedge clk);
        data_in = 1'b0; man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (evt_valid !== 1'b1) $display("FAIL bb_valid: got %b, required 1", evt_valid); else passes++;
        checks++; if (evt_code !== EVT_RELEASE) $display("FAIL bb_code: got %b, required %b", evt_code, EVT_RELEASE); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL bb_ovf: got %b, required 0", ovf); else passes++;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (evt_valid !== 1'b0) $display("FAIL bb_drain: got %b, required 0", evt_valid); else passes++;
    endtask

    task automatic test_release_on_tick;
        reset_dut();
        long_time = 8'd3; auto_ack = 1'b1;
        exp_q.push_back('{EVT_PRESS, 16'd0});
        exp_q.push_back('{EVT_RELEASE, 16'd2});
        data_in = 1'b1;
        repeat (12) @(negedge clk);
        data_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (exp_q.size() != 0) $display("FAIL rt_missing: got %0d events left, required 0", exp_q.size()); else passes++;
        checks++; if (pressed !== 1'b0) $display("FAIL rt_pressed: got %b, required 0", pressed); else passes++;
    endtask

    task automatic test_disable;
        reset_dut();
        long_time = 8'd3; auto_ack = 1'b1;
        exp_q.push_back('{EVT_PRESS, 16'd0});
        exp_q.push_back('{EVT_LONG, 16'd3});
        data_in = 1'b1;
        repeat (14) @(negedge clk);
        checks++; if (pressed !== 1'b1) $display("FAIL dis_long: got %b, required 1", pressed); else passes++;
        ena = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pressed !== 1'b0) $display("FAIL dis_idle: got %b, required 0", pressed); else passes++;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pressed !== 1'b0) $display("FAIL dis_repress: got %b, required 0", pressed); else passes++;
        ena = 1'b0; data_in = 1'b0;
        repeat (2) @(negedge clk);
        ena = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (pressed !== 1'b0) $display("FAIL dis_after: got %b, required 0", pressed); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL dis_missing: got %0d events left, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_reset_mid;
        reset_dut();
        long_time = 8'd1;
        data_in = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (ovf !== 1'b1) $display("FAIL rm_ovf_pre: got %b, required 1", ovf); else passes++;
        res = 1'b1;
        @(negedge clk);
        checks++; if ({evt_valid, evt_code, evt_hold, ovf, pressed} !== '0)
            $display("FAIL rm_outputs: got valid=%b code=%b hold=%0d ovf=%b pressed=%b, required all 0", evt_valid, evt_code, evt_hold, ovf, pressed);
        else passes++;
        res = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_PRESS)
            $display("FAIL rm_press: got valid=%b code=%b, required valid=1 code=%b", evt_valid, evt_code, EVT_PRESS);
        else passes++;
        checks++; if (pressed !== 1'b1) $display("FAIL rm_pressed: got %b, required 1", pressed); else passes++;
        data_in = 1'b0;
    endtask

    initial begin
        res = 1'b1; ena = 1'b0; data_in = 1'b0; man_ack = 1'b0; ovf_clr = 1'b0;
        auto_ack = 1'b0; long_time = 8'd0; rep_time = 8'd0;
        test_reset();
        test_press_release();
        test_long_repeat();
        test_overflow();
        test_back_to_back();
        test_release_on_tick();
        test_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
